lmdpl_gate_array: RTL and testbench
===================================

# lmdpl_gate_array

Parametrised, sequenced LMDPL (masked dual-rail precharge logic) gate array. It applies one programmable 2-input Boolean function across `WIDTH` independent lanes. Each lane gets its own input masks and output mask. An internal precharge/evaluate controller drives the rails, and a valid/ready handshake frames each operation. The block supersedes per-gate fixed-function LMDPL cells (NOR-only, externally driven precharge, no sequencing) in masked datapaths such as the AES S-box and MixColumns logic.

## Interface
- `WIDTH`, 8: number of independent lanes (≥1).
- `FUNC`, 4'b0001: truth table f(a,b), where FUNC[{b,a}] = f; the default is NOR.
- `PRE_CYCLES`, 1: precharge phase length in cycles (≥1).
- `EVAL_CYCLES`, 1: evaluate phase length in cycles (≥1).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted when `start && ready`.
- `ready`  out  1  high in IDLE and DONE.
- `in0`, `in1`  in  WIDTH  unmasked operands (testbench-side; sampled only on accept).
- `m_in0`, `m_in1`  in  WIDTH  input masks, sampled on accept.
- `m_out`  in  WIDTH  output mask, sampled on accept.
- `precharge`  out  1  high during PRE.
- `out_m`, `out_m_bar`  out  WIDTH  registered masked dual-rail result.
- `out`  out  WIDTH  registered unmasked result.
- `out_valid`  out  1  high for exactly the DONE cycle.
- `err`  out  1  high with `out_valid` if any lane's rails were equal at capture.

## Operation
- **Accept:** on `start && ready`, register the masked inputs per lane:
  - a_m = in0^m_in0, b_m = in1^m_in1.
  - Register m_in0, m_in1, m_out.
- **Tablegen (per lane):** the 8-entry table is built from the registered masks.
  - Entry for rail q_m at minterm (a_m,b_m) = f(a_m^m_in0, b_m^m_in1)^m_out.
  - The q_m_bar entry is its complement.
- **Rail gating:**
  - During PRE, both input rails are forced to 0 (a_m = a_m_bar = 0, same for b), so both output rails are 0.
  - During EVAL, input rails are driven from the registered values.
  - Rails are AND3-of-table/OR4 sum-of-products, exactly one minterm per rail.
- **FSM:** IDLE → PRE → EVAL → DONE.
  - IDLE: `ready`=1. On accept, go to PRE and load the counter with PRE_CYCLES-1.
  - PRE: `precharge`=1. Decrement the counter; at 0, go to EVAL and load EVAL_CYCLES-1.
  - EVAL: decrement the counter. At 0, capture the rails into `out_m`/`out_m_bar`, the unmasked `out`, and the error flag, then go to DONE.
  - DONE: `out_valid`=1, `ready`=1. On accept, go to PRE (back-to-back); otherwise go to IDLE.
- **Unmask (per lane):**
  - If q_m ≠ q_m_bar: out = q_m ^ m_out.
  - If q_m == q_m_bar: out = 0 and the lane is flagged; `err` = OR of lane flags.
- **Holding and ignored inputs:**
  - `out`, `out_m`, `out_m_bar` hold their values until the next capture.
  - `err` is qualified by `out_valid` (0 outside DONE).
  - `start` outside IDLE/DONE is ignored; no queueing.
  - Input changes outside the accept edge have no effect.
- **Counter width:** $clog2(max(PRE_CYCLES,EVAL_CYCLES)+1).

## Timing
- **Reset:**
  - state = IDLE.
  - `ready`=1; `precharge`=0; `out_valid`=0; `err`=0.
  - `out`, `out_m`, `out_m_bar` = 0.
  - Captured operands and masks = 0.
- **Latency:** accept at edge k, then `out_valid` is high during cycle k+PRE_CYCLES+EVAL_CYCLES (defaults: 2 cycles after the accepting edge).
- **Throughput:** one result per PRE_CYCLES+EVAL_CYCLES+1 cycles with `start` held high.
- **Precharge exposure:** every evaluation is preceded by at least PRE_CYCLES of all-zero rails, including back-to-back operations.
- **Reset mid-operation:** returns immediately to IDLE with reset values; the in-flight result is discarded and no `out_valid` is produced.
- **Simultaneous events:** `start` in DONE is accepted on the same edge that drops `out_valid`. The new operands do not disturb the outputs currently shown.

## Test plan
- **NOR exhaustive:**
  - Stimulus: default params, lane 0 swept over all in0,in1 ∈ {0,1} × all 8 (m_in0,m_in1,m_out).
  - Required: out = ~(in0|in1); out_m = out^m_out; out_m_bar = ~out_m; err = 0.
  - Example: in0=0, in1=0, m_out=1 → out=1, out_m=0, out_m_bar=1.
- **XOR, 8 lanes:**
  - Stimulus: FUNC=4'b0110, WIDTH=8, in0=8'hA5, in1=8'h3C, random masks.
  - Required: out=8'h99 and err=0 on the `out_valid` cycle.
- **Phase check:**
  - Stimulus: PRE_CYCLES=3, EVAL_CYCLES=2, accept at edge 0.
  - Required: `precharge` high for exactly cycles 0–2 after the accept; all internal rails 0 during those cycles; `out_valid` during cycle 5 only.
- **Back-to-back:**
  - Stimulus: `start` held high for 3 operations, defaults.
  - Required: `out_valid` pulses every 3 cycles; results match each accepted operand set; `precharge` high between evaluations.
- **Reset mid-EVAL:**
  - Stimulus: assert `rst` asynchronously during EVAL.
  - Required: outputs are at reset values before the next edge; no `out_valid`; a subsequent operation completes correctly.
- **Fault detect:**
  - Stimulus: force lane 3's q_m_bar equal to q_m during EVAL.
  - Required: err=1 with `out_valid`; out[3]=0; other lanes correct.

Source files
------------

// File: rtl/lmdpl_gate_array.sv
`default_nettype none
// ============================================================================
// Module  : lmdpl_gate_array
// Brief   : Sequenced masked dual-rail precharge gate array, one 2-input
//           function applied across WIDTH lanes with per-lane masks.
// Revision: 1.0 - initial release
// ============================================================================
module lmdpl_gate_array #(
  parameter int         WIDTH       = 8,
  parameter logic [3:0] FUNC        = 4'b0001,
  parameter int         PRE_CYCLES  = 1,
  parameter int         EVAL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] m_in0,
  input  logic [WIDTH-1:0] m_in1,
  input  logic [WIDTH-1:0] m_out,
  output logic             precharge,
  output logic [WIDTH-1:0] out_m,
  output logic [WIDTH-1:0] out_m_bar,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             err
);

  localparam int MAXC = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] PRE_LOAD  = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] EVAL_LOAD = CW'(EVAL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = '0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_EVAL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_m_q, b_m_q;
  logic [WIDTH-1:0] m_in0_q, m_in1_q, m_out_q;
  logic [WIDTH-1:0] out_q, out_m_q, out_m_bar_q;
  logic             flag_q;

  logic             accept;
  logic             capture;
  logic             eval_en;

  logic [WIDTH-1:0] rail_q_m;
  logic [WIDTH-1:0] rail_q_m_bar;
  logic [WIDTH-1:0] rail_diff;
  logic [WIDTH-1:0] out_d;
  logic             flag_d;

  assign ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign precharge = (state_q == ST_PRE);
  assign out_valid = (state_q == ST_DONE);
  assign eval_en   = (state_q == ST_EVAL);
  assign accept    = start && ready;

  assign out       = out_q;
  assign out_m     = out_m_q;
  assign out_m_bar = out_m_bar_q;
  assign err       = out_valid && flag_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PRE;
          cnt_d   = PRE_LOAD;
        end
      end
      ST_PRE: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_EVAL;
          cnt_d   = EVAL_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_EVAL: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_DONE;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_PRE;
          cnt_d   = PRE_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Table entry for masked minterm (am,bm): unmask operands, apply f, remask.
  function automatic logic tbl_bit(input logic am, input logic bm,
                                   input logic m0, input logic m1,
                                   input logic mo);
    logic [1:0] idx;
    idx = {bm ^ m1, am ^ m0};
    return FUNC[idx] ^ mo;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      logic       a_r, a_rb, b_r, b_rb;
      logic [3:0] tbl;

      // Rails are held low outside evaluation so every evaluation follows a precharge.
      assign a_r  = eval_en &  a_m_q[gi];
      assign a_rb = eval_en & ~a_m_q[gi];
      assign b_r  = eval_en &  b_m_q[gi];
      assign b_rb = eval_en & ~b_m_q[gi];

      assign tbl[0] = tbl_bit(1'b0, 1'b0, m_in0_q[gi], m_in1_q[gi], m_out_q[gi]);
      assign tbl[1] = tbl_bit(1'b1, 1'b0, m_in0_q[gi], m_in1_q[gi], m_out_q[gi]);
      assign tbl[2] = tbl_bit(1'b0, 1'b1, m_in0_q[gi], m_in1_q[gi], m_out_q[gi]);
      assign tbl[3] = tbl_bit(1'b1, 1'b1, m_in0_q[gi], m_in1_q[gi], m_out_q[gi]);

      assign rail_q_m[gi] = ( tbl[0] & a_rb & b_rb) | ( tbl[1] & a_r & b_rb) |
                            ( tbl[2] & a_rb & b_r ) | ( tbl[3] & a_r & b_r );
      assign rail_q_m_bar[gi] = (~tbl[0] & a_rb & b_rb) | (~tbl[1] & a_r & b_rb) |
                                (~tbl[2] & a_rb & b_r ) | (~tbl[3] & a_r & b_r );
    end
  endgenerate

  assign rail_diff = rail_q_m ^ rail_q_m_bar;
  assign out_d     = rail_diff & (rail_q_m ^ m_out_q);
  assign flag_d    = |(~rail_diff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_m_q       <= '0;
      b_m_q       <= '0;
      m_in0_q     <= '0;
      m_in1_q     <= '0;
      m_out_q     <= '0;
      out_q       <= '0;
      out_m_q     <= '0;
      out_m_bar_q <= '0;
      flag_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a_m_q   <= in0 ^ m_in0;
        b_m_q   <= in1 ^ m_in1;
        m_in0_q <= m_in0;
        m_in1_q <= m_in1;
        m_out_q <= m_out;
      end
      if (capture) begin
        out_q       <= out_d;
        out_m_q     <= rail_q_m;
        out_m_bar_q <= rail_q_m_bar;
        flag_q      <= flag_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lmdpl_gate_array.sv
`default_nettype none
// ============================================================================
// Module  : tb_lmdpl_gate_array
// Brief   : Scoreboard bench for a NOR instance and a XOR (3/2 phase) instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lmdpl_gate_array;

  typedef struct {
    logic [7:0] out;
    logic [7:0] om;
    logic [7:0] omb;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] in0_a = '0, in1_a = '0, m0_a = '0, m1_a = '0, mo_a = '0;
  logic [7:0] in0_b = '0, in1_b = '0, m0_b = '0, m1_b = '0, mo_b = '0;
  logic       ready_a, pre_a, ov_a, err_a;
  logic       ready_b, pre_b, ov_b, err_b;
  logic [7:0] om_a, omb_a, out_a, om_b, omb_b, out_b;

  lmdpl_gate_array #(.WIDTH(8), .FUNC(4'b0001), .PRE_CYCLES(1), .EVAL_CYCLES(1)) u_nor (
    .clk(clk), .rst(rst), .start(start_a), .ready(ready_a),
    .in0(in0_a), .in1(in1_a), .m_in0(m0_a), .m_in1(m1_a), .m_out(mo_a),
    .precharge(pre_a), .out_m(om_a), .out_m_bar(omb_a), .out(out_a),
    .out_valid(ov_a), .err(err_a)
  );

  lmdpl_gate_array #(.WIDTH(8), .FUNC(4'b0110), .PRE_CYCLES(3), .EVAL_CYCLES(2)) u_xor (
    .clk(clk), .rst(rst), .start(start_b), .ready(ready_b),
    .in0(in0_b), .in1(in1_b), .m_in0(m0_b), .m_in1(m1_b), .m_out(mo_b),
    .precharge(pre_b), .out_m(om_b), .out_m_bar(omb_b), .out(out_b),
    .out_valid(ov_b), .err(err_b)
  );

  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;
  exp_t qa[$];
  exp_t qb[$];
  bit   b2b_on = 1'b0;
  int   last_v = -1;
  logic [7:0] fv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: evaluate the truth table bitwise on unmasked operands.
  function automatic exp_t model(input logic [3:0] func, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] mo);
    exp_t r;
    for (int i = 0; i < 8; i++) r.out[i] = func[{b[i], a[i]}];
    r.om  = r.out ^ mo;
    r.omb = ~r.om;
    r.err = 1'b0;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ov_a) begin
        if (qa.size() == 0) begin
          tests++; failed++;
          $display("FAIL unexpected_valid_nor: got out_valid=1, required 0 (no pending op)");
        end else begin
          e = qa.pop_front();
          chk("nor_out", {24'd0, out_a}, {24'd0, e.out});
          chk("nor_out_m", {24'd0, om_a}, {24'd0, e.om});
          chk("nor_out_m_bar", {24'd0, omb_a}, {24'd0, e.omb});
          chk("nor_err", {31'd0, err_a}, {31'd0, e.err});
        end
        if (b2b_on) begin
          if (last_v >= 0) chk("b2b_spacing", cyc - last_v, 3);
          last_v = cyc;
        end
      end else begin
        chk("nor_err_qualified", {31'd0, err_a}, 32'd0);
      end
      if (ov_b) begin
        if (qb.size() == 0) begin
          tests++; failed++;
          $display("FAIL unexpected_valid_xor: got out_valid=1, required 0 (no pending op)");
        end else begin
          e = qb.pop_front();
          chk("xor_out", {24'd0, out_b}, {24'd0, e.out});
          chk("xor_out_m", {24'd0, om_b}, {24'd0, e.om});
          chk("xor_out_m_bar", {24'd0, omb_b}, {24'd0, e.omb});
          chk("xor_err", {31'd0, err_b}, {31'd0, e.err});
        end
      end else begin
        chk("xor_err_qualified", {31'd0, err_b}, 32'd0);
      end
    end
  end

  task automatic issue(input int sel, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] m0, input logic [7:0] m1,
                       input logic [7:0] mo, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    while (((sel == 0) ? !ready_a : !ready_b) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++; failed++;
      $display("FAIL ready_timeout_%0d: got ready=0 for 50 cycles, required 1", sel);
    end
    if (sel == 0) begin
      start_a = 1'b1; in0_a = a; in1_a = b; m0_a = m0; m1_a = m1; mo_a = mo;
      qa.push_back(model(4'b0001, a, b, mo));
    end else begin
      start_b = 1'b1; in0_b = a; in1_b = b; m0_b = m0; m1_b = m1; mo_b = mo;
      qb.push_back(model(4'b0110, a, b, mo));
    end
    @(posedge clk);
    if (!hold) begin
      #1;
      if (sel == 0) start_a = 1'b0;
      else          start_b = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] ra, rb, r0, r1, ro;
    exp_t e;

    #1;
    chk("rst_ready", {31'd0, ready_a}, 32'd1);
    chk("rst_precharge", {31'd0, pre_a}, 32'd0);
    chk("rst_out_valid", {31'd0, ov_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    chk("rst_out", {24'd0, out_a}, 32'd0);
    chk("rst_out_m", {24'd0, om_a}, 32'd0);
    chk("rst_out_m_bar", {24'd0, omb_a}, 32'd0);
    chk("rst_xor_ready", {31'd0, ready_b}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // NOR: lane 0 swept exhaustively over operands and masks.
    for (int x = 0; x < 32; x++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      r0 = 8'($urandom); r1 = 8'($urandom); ro = 8'($urandom);
      ra[0] = x[0]; rb[0] = x[1]; r0[0] = x[2]; r1[0] = x[3]; ro[0] = x[4];
      issue(0, ra, rb, r0, r1, ro, 1'b0);
    end
    drain();

    // XOR with 3/2 phases: fixed operands and phase timing.
    issue(1, 8'hA5, 8'h3C, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("phase_pre_c%0d", c), {31'd0, pre_b}, (c <= 2) ? 32'd1 : 32'd0);
      chk($sformatf("phase_valid_c%0d", c), {31'd0, ov_b}, (c == 5) ? 32'd1 : 32'd0);
      if (c <= 2) begin
        chk($sformatf("phase_rail_qm_c%0d", c), {24'd0, u_xor.rail_q_m}, 32'd0);
        chk($sformatf("phase_rail_qmb_c%0d", c), {24'd0, u_xor.rail_q_m_bar}, 32'd0);
      end
    end
    drain();
    for (int k = 0; k < 10; k++)
      issue(1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    drain();

    // Back-to-back with start held high.
    b2b_on = 1'b1;
    last_v = -1;
    for (int k = 0; k < 3; k++) begin
      issue(0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      @(negedge clk);
      chk("b2b_precharge", {31'd0, pre_a}, 32'd1);
    end
    #1 start_a = 1'b0;
    drain();
    b2b_on = 1'b0;
    chk("b2b_pulses_seen", {31'd0, (last_v >= 0)}, 32'd1);

    // Reset during EVAL; held output FF must be wiped.
    issue(0, 8'h00, 8'h00, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    drain();
    issue(0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    void'(qa.pop_back());
    chk("midrst_ready", {31'd0, ready_a}, 32'd1);
    chk("midrst_precharge", {31'd0, pre_a}, 32'd0);
    chk("midrst_out_valid", {31'd0, ov_a}, 32'd0);
    chk("midrst_out", {24'd0, out_a}, 32'd0);
    chk("midrst_out_m", {24'd0, om_a}, 32'd0);
    chk("midrst_out_m_bar", {24'd0, omb_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    issue(0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    drain();

    // Fault on lane 3: q_m_bar forced equal to q_m during EVAL.
    ra = 8'($urandom); rb = 8'($urandom); ro = 8'($urandom);
    issue(0, ra, rb, 8'($urandom), 8'($urandom), ro, 1'b0);
    e = qa[qa.size()-1];
    fv = e.omb;
    fv[3] = e.om[3];
    e.out[3] = 1'b0;
    e.omb = fv;
    e.err = 1'b1;
    qa[qa.size()-1] = e;
    @(posedge clk);
    #1 force u_nor.rail_q_m_bar = fv;
    @(posedge clk);
    #1 release u_nor.rail_q_m_bar;
    drain();

    for (int k = 0; k < 10; k++)
      issue(0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    drain();

    chk("drain_nor", qa.size(), 32'd0);
    chk("drain_xor", qb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
